// File: rtl/contador_hms_bcd.sv
// HH:MM:SS timekeeping core: divides clk to a 1 Hz tick and keeps six cascaded BCD digits.
// SET mode edits the time through single-cycle pulses; RUN advances it; PAUSE freezes everything.
module contador_hms_bcd #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       clr_sec,
  output logic [3:0] s_unidade,
  output logic [3:0] s_dezena,
  output logic [3:0] m_unidade,
  output logic [3:0] m_dezena,
  output logic [3:0] h_unidade,
  output logic [3:0] h_dezena,
  output logic       tick_1hz,
  output logic       day_wrap
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          sec_edge_c;
  logic          s_wrap_c, m_wrap_c, h_wrap_c;
  logic [7:0]    sec_nxt_c, min_nxt_c, hour_nxt_c;
  logic          day_nxt_c;

  // {tens, units} + 1 modulo 60
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    logic [3:0] t, u;
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 4'd5) ? 4'd0 : 4'(t + 4'd1);
    end else begin
      u = 4'(u + 4'd1);
    end
    return {t, u};
  endfunction

  // {tens, units} + 1 modulo 24
  function automatic logic [7:0] inc_mod24(input logic [7:0] v);
    logic [3:0] t, u;
    t = v[7:4];
    u = v[3:0];
    if (t == 4'd2 && u == 4'd3) begin
      t = 4'd0;
      u = 4'd0;
    end else if (u == 4'd9) begin
      t = 4'(t + 4'd1);
      u = 4'd0;
    end else begin
      u = 4'(u + 4'd1);
    end
    return {t, u};
  endfunction

  assign sec_edge_c = !set_mode && run && (presc == PRE_MAX);
  assign s_wrap_c   = (s_dezena == 4'd5) && (s_unidade == 4'd9);
  assign m_wrap_c   = (m_dezena == 4'd5) && (m_unidade == 4'd9);
  assign h_wrap_c   = (h_dezena == 4'd2) && (h_unidade == 4'd3);

  // Next digit values: SET edits take priority over the running carry chain
  always_comb begin
    sec_nxt_c  = {s_dezena, s_unidade};
    min_nxt_c  = {m_dezena, m_unidade};
    hour_nxt_c = {h_dezena, h_unidade};
    day_nxt_c  = 1'b0;
    if (set_mode) begin
      if (clr_sec)  sec_nxt_c  = 8'h00;
      if (inc_min)  min_nxt_c  = inc_mod60({m_dezena, m_unidade});
      if (inc_hour) hour_nxt_c = inc_mod24({h_dezena, h_unidade});
    end else if (sec_edge_c) begin
      sec_nxt_c = inc_mod60({s_dezena, s_unidade});
      if (s_wrap_c) begin
        min_nxt_c = inc_mod60({m_dezena, m_unidade});
        if (m_wrap_c) begin
          hour_nxt_c = inc_mod24({h_dezena, h_unidade});
          day_nxt_c  = h_wrap_c;
        end
      end
    end
  end

  // Prescaler: cleared in SET, frozen in PAUSE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (set_mode) begin
      presc <= '0;
    end else if (run) begin
      presc <= (presc == PRE_MAX) ? '0 : PW'(presc + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_unidade <= 4'd0;
      s_dezena  <= 4'd0;
      m_unidade <= 4'd0;
      m_dezena  <= 4'd0;
      h_unidade <= 4'd0;
      h_dezena  <= 4'd0;
      tick_1hz  <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      {s_dezena, s_unidade} <= sec_nxt_c;
      {m_dezena, m_unidade} <= min_nxt_c;
      {h_dezena, h_unidade} <= hour_nxt_c;
      tick_1hz              <= sec_edge_c;
      day_wrap              <= day_nxt_c;
    end
  end

endmodule
